// File: rtl/btree_find.sv
// btree_find: sequential B-tree search engine.
// Walks from a root node through a node memory, matching the search key against
// every valid key of each fetched node in parallel. Returns the matched data, or
// reports not-found at a leaf, or aborts with error once MAX_DEPTH fetches are spent.
//
// Ports:
//   clock, reset_n         rising-edge clock, synchronous active-low reset
//   start, ready           request handshake (accepted on start & ready)
//   key, root              search key and root node address, sampled on acceptance
//   mem_req, mem_addr      one-cycle read strobe; address held until the response
//   mem_valid, mem_data    node read response (ignored unless waiting for one)
//   done                   one-cycle result pulse
//   found, data, error     result, stable from done until the next acceptance
//   steps                  number of node fetches issued for this search
//
// Node layout, LSB first: key[0..KEYS-1], data[0..KEYS-1], child[0..KEYS],
// count (CNT_W), leaf (MSB).
module btree_find #(
  parameter int unsigned KEYS      = 3,
  parameter int unsigned KEY_W     = 4,
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MAX_DEPTH = 8,
  parameter int unsigned CNT_W     = $clog2(KEYS + 1),
  parameter int unsigned NODE_W    = KEYS * (KEY_W + DATA_W) + (KEYS + 1) * ADDR_W + CNT_W + 1,
  localparam int unsigned STEP_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              ready,
  input  logic [KEY_W-1:0]  key,
  input  logic [ADDR_W-1:0] root,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [NODE_W-1:0] mem_data,
  output logic              done,
  output logic              found,
  output logic [DATA_W-1:0] data,
  output logic              error,
  output logic [STEP_W-1:0] steps
);

  localparam int unsigned DATA_LO  = KEYS * KEY_W;
  localparam int unsigned CHILD_LO = KEYS * (KEY_W + DATA_W);
  localparam int unsigned CNT_LO   = CHILD_LO + (KEYS + 1) * ADDR_W;
  localparam int unsigned LEAF_BIT = NODE_W - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [KEY_W-1:0]  key_q;

  // Node decode of the current response
  logic [CNT_W-1:0]  cnt_raw;
  logic [CNT_W-1:0]  eff_cnt;
  logic              node_leaf;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic [CNT_W-1:0]  n_less;
  logic [ADDR_W-1:0] desc_addr;
  logic              at_limit;

  always_comb begin
    cnt_raw   = mem_data[CNT_LO +: CNT_W];
    eff_cnt   = (cnt_raw > CNT_W'(KEYS)) ? CNT_W'(KEYS) : cnt_raw;
    node_leaf = mem_data[LEAF_BIT];
    hit       = 1'b0;
    hit_data  = '0;
    n_less    = '0;
    desc_addr = '0;
    // Keys need not be sorted: the child index is a count of valid keys below
    // the search key, and the first (lowest-index) equal key wins.
    for (int unsigned i = 0; i < KEYS; i++) begin
      if (CNT_W'(i) < eff_cnt) begin
        if (!hit && (mem_data[i*KEY_W +: KEY_W] == key_q)) begin
          hit      = 1'b1;
          hit_data = mem_data[DATA_LO + i*DATA_W +: DATA_W];
        end
        if (mem_data[i*KEY_W +: KEY_W] < key_q) begin
          n_less = n_less + CNT_W'(1);
        end
      end
    end
    for (int unsigned i = 0; i <= KEYS; i++) begin
      if (CNT_W'(i) == n_less) begin
        desc_addr = mem_data[CHILD_LO + i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign at_limit = (steps == STEP_W'(MAX_DEPTH));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (start) state_next = S_FETCH;
      S_FETCH: state_next = S_WAIT;
      S_WAIT: begin
        if (mem_valid) begin
          if (hit || node_leaf || at_limit) state_next = S_DONE;
          else                              state_next = S_FETCH;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the
  // state they belong to without any combinational output path.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ready    <= 1'b1;
      mem_req  <= 1'b0;
      done     <= 1'b0;
      mem_addr <= '0;
      found    <= 1'b0;
      data     <= '0;
      error    <= 1'b0;
      steps    <= '0;
      key_q    <= '0;
    end else begin
      ready   <= (state_next == S_IDLE);
      mem_req <= (state_next == S_FETCH);
      done    <= (state_next == S_DONE);
      unique case (state)
        S_IDLE: begin
          if (start) begin
            key_q    <= key;
            mem_addr <= root;
            found    <= 1'b0;
            data     <= '0;
            error    <= 1'b0;
            steps    <= '0;
          end
        end
        S_FETCH: steps <= steps + STEP_W'(1);
        S_WAIT: begin
          if (mem_valid) begin
            if (hit) begin
              found <= 1'b1;
              data  <= hit_data;
            end else if (node_leaf) begin
              found <= 1'b0;
              data  <= '0;
            end else if (at_limit) begin
              error <= 1'b1;
            end else begin
              mem_addr <= desc_addr;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_btree_find.sv
// Self-checking bench for btree_find: scoreboard of expected results fed by a
// tree-walk reference model over the bench's own node memory; a variable-latency
// memory responder with optional spurious mem_valid pulses.
module tb_btree_find;

  localparam int unsigned KEYS   = 3;
  localparam int unsigned KEY_W  = 4;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned MAXD   = 3;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned NODE_W = 59;
  localparam int unsigned STEP_W = 2;

  logic              clock;
  logic              reset_n;
  logic              start;
  logic              ready;
  logic [KEY_W-1:0]  key;
  logic [ADDR_W-1:0] root;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic [NODE_W-1:0] mem_data;
  logic              done;
  logic              found;
  logic [DATA_W-1:0] data;
  logic              error;
  logic [STEP_W-1:0] steps;

  btree_find #(
    .KEYS(KEYS), .KEY_W(KEY_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_DEPTH(MAXD)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .ready(ready), .key(key),
    .root(root), .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid),
    .mem_data(mem_data), .done(done), .found(found), .data(data), .error(error),
    .steps(steps)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       found;
    logic [3:0] data;
    logic       error;
    int         steps;
    int         lat;
    int         acc;
  } exp_t;

  logic [NODE_W-1:0] mem [256];
  exp_t              exp_q[$];
  logic [7:0]        addr_log[$];
  int                n_chk = 0;
  int                n_err = 0;
  int                cyc = 0;
  int                lat_mode = 0;
  bit                spur_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [NODE_W-1:0] make_node(input logic [11:0] ks, input logic [11:0] ds,
                                                  input logic [31:0] cs, input logic [1:0] cnt,
                                                  input logic leaf);
    return {leaf, cnt, cs, ds, ks};
  endfunction

  // Reference: walk the tree from the root using the bench memory.
  function automatic void model(input logic [3:0] k, input logic [7:0] r, output exp_t e);
    logic [NODE_W-1:0] nd;
    logic [7:0]        a;
    int                c, n;
    a = r;
    e.found = 0; e.data = 0; e.error = 0; e.steps = 0; e.lat = -1; e.acc = 0;
    for (int d = 1; d <= int'(MAXD); d++) begin
      nd = mem[a];
      e.steps = d;
      c = int'(nd[57:56]);
      if (c > 3) c = 3;
      for (int i = 0; i < c; i++) begin
        if (nd[i*4 +: 4] == k) begin
          e.found = 1;
          e.data  = nd[12 + i*4 +: 4];
          return;
        end
      end
      if (nd[58]) return;
      if (d == int'(MAXD)) begin
        e.error = 1;
        return;
      end
      n = 0;
      for (int i = 0; i < c; i++) if (nd[i*4 +: 4] < k) n++;
      a = nd[24 + n*8 +: 8];
    end
  endfunction

  function automatic int pick_lat();
    if (lat_mode == 0) return 1;
    if (lat_mode == 2) return 5;
    return int'($urandom_range(1, 5));
  endfunction

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Memory responder: latency counted from the mem_req cycle.
  initial begin
    bit         pend;
    int         rcnt;
    logic [7:0] raddr;
    pend = 0; rcnt = 0; raddr = 0;
    mem_valid = 0;
    mem_data  = '0;
    forever begin
      @(negedge clock);
      mem_valid = 0;
      if (pend) begin
        chk("mem_req_single", mem_req, 0);
        rcnt--;
        if (rcnt == 0) begin
          mem_valid = 1;
          mem_data  = mem[raddr];
          pend      = 0;
        end
      end else begin
        if (mem_req) begin
          pend  = 1;
          raddr = mem_addr;
          rcnt  = pick_lat();
          addr_log.push_back(mem_addr);
        end
        if (spur_en && $urandom_range(0, 2) == 0) begin
          mem_valid = 1;
          mem_data  = {$urandom, $urandom};
        end
      end
    end
  end

  // Monitor: compare each done pulse with the oldest expectation.
  initial forever begin
    exp_t e;
    @(negedge clock);
    if (reset_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", done, 0);
      end else begin
        e = exp_q.pop_front();
        chk("found", found, e.found);
        chk("data", data, e.data);
        chk("error", error, e.error);
        chk("steps", steps, e.steps);
        if (e.lat >= 0) chk("latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic issue(input logic [3:0] k, input logic [7:0] r, input bit timed);
    exp_t e;
    int   t;
    @(negedge clock);
    t = 0;
    while (!ready && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (!ready) begin
      chk("ready_timeout", ready, 1);
      return;
    end
    model(k, r, e);
    e.lat = timed ? 1 + 2 * e.steps : -1;
    e.acc = cyc;
    exp_q.push_back(e);
    start = 1; key = k; root = r;
    @(negedge clock);
    start = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !ready) && t < 1000) begin
      @(negedge clock);
      t++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_found"}, found, 0);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_steps"}, steps, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0; start = 0; key = 0; root = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = make_node({4'h9, 4'h5, 4'h2}, {4'hC, 4'hB, 4'hA}, 32'h0, 2'd3, 1'b1);
    mem[8'h20] = make_node({4'hC, 4'h8, 4'h4}, 12'h0, {8'h24, 8'h23, 8'h22, 8'h21}, 2'd3, 1'b0);
    mem[8'h23] = make_node({4'hF, 4'h1, 4'hA}, 12'h0, {8'h33, 8'h32, 8'h30, 8'h31}, 2'd3, 1'b0);
    mem[8'h30] = make_node({4'hE, 4'h9, 4'h3}, {4'h2, 4'h7, 4'h1}, 32'h0, 2'd3, 1'b1);
    mem[8'h40] = make_node({4'h6, 4'h3, 4'h1}, {4'h8, 4'h5, 4'h4}, 32'h0, 2'd2, 1'b1);
    mem[8'h50] = make_node({4'h3, 4'h2, 4'h1}, 12'h0, {8'hFF, 8'hFF, 8'hFF, 8'h51}, 2'd3, 1'b0);
    mem[8'h51] = make_node(12'h0, 12'h0, {8'hFF, 8'hFF, 8'hFF, 8'h52}, 2'd0, 1'b0);
    mem[8'h52] = make_node({4'h3, 4'h2, 4'h1}, 12'h0, {8'hFF, 8'hFF, 8'hFF, 8'h53}, 2'd3, 1'b0);

    repeat (3) @(negedge clock);
    chk_reset_vals("in_reset");
    reset_n = 1;
    @(negedge clock);
    chk_reset_vals("after_reset");

    // Single-level leaf hit
    issue(4'h5, 8'h10, 1);
    drain();

    // Three-level descent; a start pulse mid-search must be ignored
    addr_log.delete();
    issue(4'h9, 8'h20, 1);
    start = 1; key = 4'h0; root = 8'h40;
    repeat (2) @(negedge clock);
    start = 0;
    drain();
    chk("addr_log_len", addr_log.size(), 3);
    if (addr_log.size() == 3) begin
      chk("addr0", addr_log[0], 8'h20);
      chk("addr1", addr_log[1], 8'h23);
      chk("addr2", addr_log[2], 8'h30);
    end

    // Stale key beyond count must not match
    issue(4'h6, 8'h40, 1);
    drain();

    // Non-matching chain hits the depth limit (includes a count=0 node)
    addr_log.delete();
    issue(4'h0, 8'h50, 1);
    drain();
    chk("depth_req_count", addr_log.size(), MAXD);

    // Randomized trees, random latency, spurious mem_valid
    for (int a = 8'h80; a < 256; a++) begin
      logic [31:0] r0, r1;
      r0 = $urandom; r1 = $urandom;
      mem[a] = make_node(r0[11:0], r0[23:12], {1'b1, r1[30:24], 1'b1, r1[22:16], 1'b1, r1[14:8], 1'b1, r1[6:0]},
                         r0[25:24], (r0[27:26] == 2'b00));
    end
    lat_mode = 1;
    spur_en  = 1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] rk;
      rk = $urandom;
      issue(rk[3:0], {1'b1, rk[10:4]}, 0);
    end
    issue(4'h9, 8'h20, 0);
    issue(4'h6, 8'h40, 0);
    issue(4'h5, 8'h10, 0);
    issue(4'h0, 8'h50, 0);
    drain();

    // Reset while waiting for the memory; the late response must be dropped
    spur_en  = 0;
    lat_mode = 2;
    issue(4'h5, 8'h10, 0);
    @(negedge clock);
    reset_n = 0;
    exp_q.delete();
    @(negedge clock);
    chk_reset_vals("wait_reset");
    reset_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("no_done_after_reset", done, 0);
    end
    chk_reset_vals("post_abort");
    lat_mode = 0;
    issue(4'hC, 8'h10, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
